// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: a fetch port (imem) and a data port (dmem)
// share one memory port. At most one transaction is in flight.
// The data port wins by default. A starvation counter forces a fetch grant
// after STARVE_LIMIT data grants while a fetch is waiting.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic        imem_rvalid,
  output logic [31:0] imem_rdata,
  input  logic        dmem_req,
  input  logic [3:0]  dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_ready,
  output logic        dmem_rvalid,
  output logic [31:0] dmem_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stray_rsp
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;

  state_t          state, state_next;
  owner_t          owner, owner_next;
  logic [CW-1:0]   starve_cnt, starve_next;
  logic            forced, sel_dmem, sel_imem;

  // State register: FSM state, owner of the outstanding transaction, starvation count
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IMEM;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      starve_cnt <= starve_next;
    end
  end

  // Arbitration, next-state logic and all outputs; reset forces outputs low
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    starve_next = starve_cnt;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 4'h0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    stray_rsp   = 1'b0;
    imem_rdata  = mem_rdata;
    dmem_rdata  = mem_rdata;
    forced      = imem_req && (starve_cnt == LIMIT);
    sel_dmem    = dmem_req && !forced;
    sel_imem    = imem_req && !sel_dmem;

    if (!rst) begin
      unique case (state)
        IDLE: begin
          mem_req    = imem_req | dmem_req;
          if (sel_dmem) begin
            mem_we    = dmem_we;
            mem_addr  = dmem_addr;
            mem_wdata = dmem_wdata;
          end else if (sel_imem) begin
            mem_addr  = imem_addr;
          end
          imem_ready = mem_gnt & sel_imem;
          dmem_ready = mem_gnt & sel_dmem;
          // A response can never belong to a grant made in this same cycle
          stray_rsp  = mem_rvalid;
          if (!imem_req) begin
            starve_next = '0;
          end
          if (mem_gnt && (imem_req || dmem_req)) begin
            state_next = WAIT;
            owner_next = sel_dmem ? OWN_DMEM : OWN_IMEM;
            if (sel_imem) begin
              starve_next = '0;
            end else if (imem_req && (starve_cnt != LIMIT)) begin
              starve_next = starve_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          imem_rvalid = mem_rvalid & (owner == OWN_IMEM);
          dmem_rvalid = mem_rvalid & (owner == OWN_DMEM);
          if (mem_rvalid) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stray_rsp;

  int    checks_total = 0;
  int    checks_passed = 0;

  // Model: is a transaction outstanding, who owns it, and how many data
  // grants in a row the waiting fetch has suffered.
  bit    m_busy = 1'b0;
  bit    m_own_d = 1'b0;
  int    m_starve = 0;
  bit    log_en = 1'b0;
  string grant_log = "";

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stray_rsp(stray_rsp)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic [3:0] dw,
                               input logic [31:0] da, input logic [31:0] dd,
                               input logic g, input logic rv, input logic [31:0] rd);
    rst = r; imem_req = ir; imem_addr = ia;
    dmem_req = dr; dmem_we = dw; dmem_addr = da; dmem_wdata = dd;
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
  endtask

  // Which requester the rules pick from the current model state and inputs
  function automatic bit modelPicksData();
    return dmem_req && !(imem_req && m_starve >= LIMIT);
  endfunction

  // Settle, then compare every output with what the model says it must be
  task automatic evalCycle();
    logic        e_req, e_iready, e_dready, e_irv, e_drv, e_stray;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wdata;
    bit          pd, pi;
    #1;
    e_req = 0; e_iready = 0; e_dready = 0; e_irv = 0; e_drv = 0; e_stray = 0;
    e_we = 0; e_addr = 0; e_wdata = 0;
    pd = modelPicksData();
    pi = imem_req && !pd;
    if (!rst) begin
      if (!m_busy) begin
        e_req    = imem_req | dmem_req;
        e_iready = mem_gnt & pi;
        e_dready = mem_gnt & pd;
        e_stray  = mem_rvalid;
        if (pd) begin e_we = dmem_we; e_addr = dmem_addr; e_wdata = dmem_wdata; end
        else if (pi) e_addr = imem_addr;
      end else begin
        e_irv = mem_rvalid & !m_own_d;
        e_drv = mem_rvalid & m_own_d;
      end
    end
    checkOutput("mem_req", {31'b0, mem_req}, {31'b0, e_req});
    checkOutput("mem_we", {28'b0, mem_we}, {28'b0, e_we});
    checkOutput("mem_addr", mem_addr, e_addr);
    checkOutput("mem_wdata", mem_wdata, e_wdata);
    checkOutput("imem_ready", {31'b0, imem_ready}, {31'b0, e_iready});
    checkOutput("dmem_ready", {31'b0, dmem_ready}, {31'b0, e_dready});
    checkOutput("imem_rvalid", {31'b0, imem_rvalid}, {31'b0, e_irv});
    checkOutput("dmem_rvalid", {31'b0, dmem_rvalid}, {31'b0, e_drv});
    checkOutput("stray_rsp", {31'b0, stray_rsp}, {31'b0, e_stray});
    checkOutput("imem_rdata", imem_rdata, mem_rdata);
    checkOutput("dmem_rdata", dmem_rdata, mem_rdata);
    if (log_en && dmem_ready) grant_log = {grant_log, "D"};
    if (log_en && imem_ready) grant_log = {grant_log, "I"};
  endtask

  // Advance the model with the inputs the DUT is about to sample, then clock
  task automatic advanceCycle();
    bit pd, pi;
    pd = modelPicksData();
    pi = imem_req && !pd;
    if (rst) begin
      m_busy = 0; m_own_d = 0; m_starve = 0;
    end else if (!m_busy) begin
      if (!imem_req) m_starve = 0;
      if (mem_gnt && (imem_req || dmem_req)) begin
        m_busy  = 1;
        m_own_d = pd;
        if (pi) m_starve = 0;
        else if (imem_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      end
    end else if (mem_rvalid) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycle();
    applyStimulus(1, 1, 32'h1000, 1, 4'hF, 32'h2000, 32'h1, 1, 1, 32'h0);
    evalCycle();
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_ready", {30'b0, imem_ready, dmem_ready}, 32'd0);
    checkOutput("rst_stray", {31'b0, stray_rsp}, 32'd0);
    advanceCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    evalCycle();
    advanceCycle();
  endtask

  // Stimulus and checking sequence
  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    resetCycle();

    // Fetch read: grant at 0, response at 2
    applyStimulus(0, 1, 32'h1000, 0, 0, 0, 0, 1, 0, 0);
    evalCycle();
    checkOutput("fetch_ready", {31'b0, imem_ready}, 32'd1);
    checkOutput("fetch_addr", mem_addr, 32'h1000);
    advanceCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    evalCycle();
    checkOutput("fetch_early_rvalid", {31'b0, imem_rvalid}, 32'd0);
    advanceCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00000013);
    evalCycle();
    checkOutput("fetch_rvalid", {31'b0, imem_rvalid}, 32'd1);
    checkOutput("fetch_rdata", imem_rdata, 32'h00000013);
    checkOutput("fetch_no_drvalid", {31'b0, dmem_rvalid}, 32'd0);
    advanceCycle();
    idleCycle();

    // Simultaneous requests: data store wins, fetch follows the response
    applyStimulus(0, 1, 32'h1004, 1, 4'hF, 32'h2000, 32'hDEADBEEF, 1, 0, 0);
    evalCycle();
    checkOutput("sim_we", {28'b0, mem_we}, 32'hF);
    checkOutput("sim_addr", mem_addr, 32'h2000);
    checkOutput("sim_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("sim_dready", {31'b0, dmem_ready}, 32'd1);
    checkOutput("sim_iready", {31'b0, imem_ready}, 32'd0);
    advanceCycle();
    applyStimulus(0, 1, 32'h1004, 0, 0, 0, 0, 1, 1, 32'h55);
    evalCycle();
    checkOutput("sim_drvalid", {31'b0, dmem_rvalid}, 32'd1);
    checkOutput("sim_wait_req", {31'b0, mem_req}, 32'd0);
    advanceCycle();
    applyStimulus(0, 1, 32'h1004, 0, 0, 0, 0, 1, 0, 0);
    evalCycle();
    checkOutput("sim_fetch_after", {31'b0, imem_ready}, 32'd1);
    checkOutput("sim_fetch_addr", mem_addr, 32'h1004);
    advanceCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66);
    evalCycle();
    advanceCycle();

    // Starvation: both always requesting, one-cycle memory latency
    resetCycle();
    grant_log = "";
    log_en = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 32'h100, 1, 4'h0, 32'h200, 0, 1, m_busy, 32'h77);
      evalCycle();
      advanceCycle();
    end
    log_en = 0;
    checks_total++;
    if (grant_log == "DDDDIDDDDI") checks_passed++;
    else $display("[TB] FAIL grant_order: got %s, expected DDDDIDDDDI", grant_log);

    // Back-pressure: three cycles without a grant, then granted
    resetCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
      evalCycle();
      checkOutput("bp_mem_req", {31'b0, mem_req}, 32'd1);
      checkOutput("bp_iready", {31'b0, imem_ready}, 32'd0);
      advanceCycle();
    end
    applyStimulus(0, 1, 32'h3000, 0, 0, 0, 0, 1, 0, 0);
    evalCycle();
    checkOutput("bp_grant", {31'b0, imem_ready}, 32'd1);
    advanceCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88);
    evalCycle();
    checkOutput("bp_rvalid", {31'b0, imem_rvalid}, 32'd1);
    advanceCycle();

    // Reset while a data load is outstanding
    resetCycle();
    applyStimulus(0, 0, 0, 1, 4'h0, 32'h4000, 0, 1, 0, 0);
    evalCycle();
    checkOutput("rmid_dready", {31'b0, dmem_ready}, 32'd1);
    advanceCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    evalCycle();
    advanceCycle();
    idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
    evalCycle();
    checkOutput("rmid_drvalid", {31'b0, dmem_rvalid}, 32'd0);
    checkOutput("rmid_stray", {31'b0, stray_rsp}, 32'd1);
    advanceCycle();
    applyStimulus(0, 1, 32'h5000, 0, 0, 0, 0, 0, 0, 0);
    evalCycle();
    checkOutput("rmid_stray_end", {31'b0, stray_rsp}, 32'd0);
    checkOutput("rmid_idle", {31'b0, mem_req}, 32'd1);
    advanceCycle();

    // Stray response with nothing outstanding
    resetCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAA);
    evalCycle();
    checkOutput("stray_pulse", {31'b0, stray_rsp}, 32'd1);
    checkOutput("stray_rvalids", {30'b0, imem_rvalid, dmem_rvalid}, 32'd0);
    advanceCycle();
    idleCycle();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 9) < 6), $urandom,
                    ($urandom_range(0, 9) < 6),
                    $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                    $urandom, $urandom,
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 4), $urandom);
      evalCycle();
      advanceCycle();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants while a fetch request waits.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port imem_req, input, 1: fetch requester wants one read.
REQ-005 SHALL have port imem_addr, input, 32: fetch address.
REQ-006 SHALL have port imem_ready, output, 1: fetch request accepted this cycle.
REQ-007 SHALL have ports imem_rvalid, output, 1 and imem_rdata, output, 32: fetch response.
REQ-008 SHALL have ports dmem_req, input, 1; dmem_we, input, 4; dmem_addr, input, 32; dmem_wdata, input, 32: data requester; dmem_we==0 means load.
REQ-009 SHALL have ports dmem_ready, output, 1; dmem_rvalid, output, 1; dmem_rdata, output, 32: data accept and response.
REQ-010 SHALL have ports mem_req, output, 1; mem_we, output, 4; mem_addr, output, 32; mem_wdata, output, 32: shared memory request.
REQ-011 SHALL have ports mem_gnt, input, 1; mem_rvalid, input, 1; mem_rdata, input, 32: memory accept and response; a response arrives one or more cycles after the grant, writes included.
REQ-012 SHALL have port stray_rsp, output, 1: one-cycle pulse when mem_rvalid arrives with no transaction outstanding.

Function
REQ-013 SHALL implement two states: IDLE (no transaction outstanding) and WAIT (one transaction outstanding); at most one transaction SHALL be in flight.
REQ-014 In IDLE, selection SHALL be: dmem if dmem_req and not forced; else imem if imem_req; forced means imem_req and starve_cnt==STARVE_LIMIT, which selects imem.
REQ-015 In IDLE, mem_req SHALL equal the OR of the requests, driven combinationally.
REQ-016 In IDLE, mem_addr, mem_we and mem_wdata SHALL come from the selected requester; mem_we SHALL be 0 when imem is selected.
REQ-017 imem_ready SHALL equal IDLE & mem_gnt & (imem selected), combinationally.
REQ-018 dmem_ready SHALL equal IDLE & mem_gnt & (dmem selected), combinationally.
REQ-019 On IDLE & mem_req & mem_gnt, the block SHALL register owner (IMEM/DMEM) and go to WAIT next cycle.
REQ-020 mem_req with no mem_gnt SHALL hold IDLE and re-arbitrate next cycle; requests are not latched.
REQ-021 In WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL be 0; imem_ready and dmem_ready SHALL be 0.
REQ-022 In WAIT with mem_rvalid, the block SHALL assert the owner's rvalid for that cycle only and return to IDLE next cycle.
REQ-023 imem_rdata and dmem_rdata SHALL both pass mem_rdata through combinationally; rvalid alone qualifies them.
REQ-024 Minimum spacing SHALL be: grant cycle N, response at N+1 at earliest, next grant at N+2 at earliest.
REQ-025 starve_cnt, 0..STARVE_LIMIT, SHALL increment on each dmem grant while imem_req=1, saturating at STARVE_LIMIT.
REQ-026 starve_cnt SHALL clear to 0 on any imem grant, and in any IDLE cycle with imem_req=0.
REQ-027 mem_rvalid in IDLE SHALL pulse stray_rsp for one cycle, assert neither requester's rvalid, and leave state unchanged.
REQ-028 mem_rvalid in the grant cycle itself SHALL be treated as stray (REQ-027).

Reset
REQ-029 On rst at the clock edge: state SHALL become IDLE, owner IMEM, starve_cnt 0, stray_rsp 0.
REQ-030 With rst asserted, all outputs except the combinational rdata pass-through SHALL be 0, overriding REQ-015 to REQ-018.
REQ-031 Reset in WAIT SHALL abandon the outstanding transaction; its later response SHALL produce stray_rsp only.

Verification
REQ-032 SHALL cover fetch read: imem_req=1, addr=0x1000, mem_gnt=1 at cycle 0, mem_rvalid=1 with rdata=0x00000013 at cycle 2 -> imem_ready at 0, imem_rvalid with 0x00000013 at 2, dmem_rvalid 0 throughout.
REQ-033 SHALL cover simultaneous requests: both requesting, dmem store we=4'b1111, addr=0x2000, wdata=0xDEADBEEF -> mem_we=4'b1111, mem_addr=0x2000, mem_wdata=0xDEADBEEF, dmem_ready=1, imem_ready=0, then imem granted after the response.
REQ-034 SHALL cover starvation: both requesting continuously, 1-cycle memory latency, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 SHALL cover back-pressure: imem_req=1 with mem_gnt=0 for 3 cycles -> mem_req=1 and imem_ready=0 for 3 cycles, state stays IDLE, grant on the 4th cycle.
REQ-036 SHALL cover reset mid-operation: rst=1 in WAIT after a dmem grant, response 2 cycles later -> dmem_rvalid=0, stray_rsp=1 for one cycle, state IDLE.
REQ-037 SHALL cover a stray response: mem_rvalid=1 in IDLE with no prior grant -> stray_rsp=1 for one cycle, imem_rvalid=0 and dmem_rvalid=0.
